// File: rtl/irq_priority_dispatcher.sv
// Interrupt dispatcher: latches IRQ edges and sw pulses into pending, and dispatches the lowest unmasked index.
// Latency: irq edge -> pending +1 cycle -> ack_start +2 cycles; svc_done -> ack_end +1 cycle.
// Backpressure: one interrupt in flight; new events accumulate in pending until the FSM returns to IDLE.
module irq_priority_dispatcher #(
    parameter int N           = 32,
    parameter int ID_WIDTH    = 5,
    parameter int SVC_TIMEOUT = 1024,
    parameter int TO_WIDTH    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        irq_req,
    input  logic [N-1:0]        sw_flag,
    input  logic [N-1:0]        irq_mask,
    input  logic                svc_done,
    input  logic                err_clr,
    output logic [ID_WIDTH-1:0] int_ID,
    output logic                ack_start,
    output logic                ack_end,
    output logic                busy,
    output logic [N-1:0]        pending,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_SERVICE,
        S_COMPLETE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [N-1:0]         irq_req_q;
    logic [N-1:0]         irq_mask_q;
    logic [N-1:0]         evt;
    logic [N-1:0]         eligible;
    logic [N-1:0]         clr_vec;
    logic [ID_WIDTH-1:0]  sel;
    logic                 any_elig;
    logic                 grant;
    logic                 set_err;
    logic                 timeout_hit;
    logic [TO_WIDTH-1:0]  to_cnt;

    assign evt         = (irq_req & ~irq_req_q) | sw_flag;
    // The registered mask makes an unmask take effect on the following IDLE cycle.
    assign eligible    = pending & ~irq_mask_q;
    assign timeout_hit = (to_cnt == TO_WIDTH'(SVC_TIMEOUT - 1));

    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel      = ID_WIDTH'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        set_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    grant   = 1'b1;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: state_d = S_SERVICE;
            S_SERVICE: begin
                if (svc_done) begin
                    state_d = S_COMPLETE;
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_d = S_COMPLETE;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clr_vec = '0;
        if (grant) begin
            clr_vec[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            irq_req_q   <= '0;
            irq_mask_q  <= '0;
            pending     <= '0;
            int_ID      <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_req_q  <= irq_req;
            irq_mask_q <= irq_mask;
            // A same-cycle event on the granted bit overrides its clear.
            pending    <= (pending & ~clr_vec) | evt;
            if (grant) begin
                int_ID <= sel;
            end
            if (state_q == S_DISPATCH) begin
                to_cnt <= '0;
            end else if (state_q == S_SERVICE) begin
                to_cnt <= to_cnt + TO_WIDTH'(1);
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign ack_start = (state_q == S_DISPATCH);
    assign ack_end   = (state_q == S_COMPLETE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_irq_priority_dispatcher.sv
// Directed scenarios plus a randomized run compared against a cycle reference model of the dispatcher rules.
module tb_irq_priority_dispatcher;
    localparam int N   = 32;
    localparam int IDW = 5;
    localparam int TO  = 16;
    localparam int TOW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq_req, sw_flag, irq_mask;
    logic           svc_done, err_clr;
    logic [IDW-1:0] int_ID;
    logic           ack_start, ack_end, busy, timeout_err;
    logic [N-1:0]   pending;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: pending as a plain bit array, phase 0..3 = idle/dispatch/service/complete.
    bit [N-1:0]   m_pend, m_prev, m_mask_q;
    bit [IDW-1:0] m_id;
    int           m_phase, m_cnt;
    bit           m_err;

    irq_priority_dispatcher #(.N(N), .ID_WIDTH(IDW), .SVC_TIMEOUT(TO), .TO_WIDTH(TOW)) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .sw_flag(sw_flag), .irq_mask(irq_mask),
        .svc_done(svc_done), .err_clr(err_clr), .int_ID(int_ID), .ack_start(ack_start),
        .ack_end(ack_end), .busy(busy), .pending(pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit [N-1:0] evt;
        bit [N-1:0] elig;
        bit         set_e;
        int         s;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_mask_q = '0; m_id = '0;
            m_phase = 0; m_cnt = 0; m_err = 1'b0;
            return;
        end
        evt   = (irq_req & ~m_prev) | sw_flag;
        elig  = m_pend & ~m_mask_q;
        set_e = 1'b0;
        if (m_phase == 0) begin
            if (elig != 0) begin
                s = 0;
                while (!elig[s]) s++;
                m_pend[s] = 1'b0;
                m_id      = IDW'(s);
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            m_cnt   = 0;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (svc_done) m_phase = 3;
            else if (m_cnt == TO - 1) begin
                set_e   = 1'b1;
                m_phase = 3;
            end
            m_cnt++;
        end else begin
            m_phase = 0;
        end
        m_pend   = m_pend | evt;
        m_prev   = irq_req;
        m_mask_q = irq_mask;
        if (set_e) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++; if (pending !== '0) $display("FAIL reset_pending got=%h exp=0", pending); else pass_cnt++;
        total_cnt++; if (int_ID !== '0) $display("FAIL reset_int_ID got=%0d exp=0", int_ID); else pass_cnt++;
        total_cnt++; if ({ack_start, ack_end, busy, timeout_err} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {ack_start, ack_end, busy, timeout_err}); else pass_cnt++;
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic test_basic();
        irq_req[5] = 1'b1;
        step();
        total_cnt++; if ({pending[5], ack_start} !== 2'b10) $display("FAIL basic_pend got=%b exp=10", {pending[5], ack_start}); else pass_cnt++;
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd5}) $display("FAIL basic_dispatch got=%b/%0d exp=1/5", ack_start, int_ID); else pass_cnt++;
        total_cnt++; if (pending[5] !== 1'b0) $display("FAIL basic_clear got=%b exp=0", pending[5]); else pass_cnt++;
        step();
        total_cnt++; if ({busy, ack_start} !== 2'b10) $display("FAIL basic_service got=%b exp=10", {busy, ack_start}); else pass_cnt++;
        repeat (5) step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        total_cnt++; if ({ack_end, int_ID} !== {1'b1, 5'd5}) $display("FAIL basic_ack_end got=%b/%0d exp=1/5", ack_end, int_ID); else pass_cnt++;
        step();
        total_cnt++; if ({busy, ack_end, int_ID} !== {2'b00, 5'd5}) $display("FAIL basic_idle_hold got=%b/%0d exp=00/5", {busy, ack_end}, int_ID); else pass_cnt++;
        irq_req[5] = 1'b0;
        step();
    endtask

    task automatic test_priority();
        sw_flag[3] = 1'b1; sw_flag[17] = 1'b1;
        step();
        sw_flag = '0;
        total_cnt++; if (pending !== 32'h0002_0008) $display("FAIL prio_pend got=%h exp=00020008", pending); else pass_cnt++;
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd3}) $display("FAIL prio_first got=%b/%0d exp=1/3", ack_start, int_ID); else pass_cnt++;
        total_cnt++; if (pending !== 32'h0002_0000) $display("FAIL prio_left got=%h exp=00020000", pending); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        total_cnt++; if (ack_end !== 1'b1) $display("FAIL prio_end3 got=%b exp=1", ack_end); else pass_cnt++;
        step();
        total_cnt++; if (ack_start !== 1'b0) $display("FAIL prio_gap got=%b exp=0", ack_start); else pass_cnt++;
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd17}) $display("FAIL prio_second got=%b/%0d exp=1/17", ack_start, int_ID); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        step();
    endtask

    task automatic test_mask();
        irq_mask[2] = 1'b1;
        irq_req[2]  = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if ({busy, ack_start, pending[2]} !== 3'b001)
                $display("FAIL mask_hold got=%b exp=001", {busy, ack_start, pending[2]}); else pass_cnt++;
        end
        irq_mask[2] = 1'b0;
        step();
        total_cnt++; if (ack_start !== 1'b0) $display("FAIL mask_lag got=%b exp=0", ack_start); else pass_cnt++;
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd2}) $display("FAIL mask_release got=%b/%0d exp=1/2", ack_start, int_ID); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        irq_req[2] = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        irq_req[7] = 1'b1;
        step();
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd7}) $display("FAIL to_dispatch got=%b/%0d exp=1/7", ack_start, int_ID); else pass_cnt++;
        step();
        for (int i = 2; i <= 16; i++) begin
            step();
            total_cnt++; if (ack_end !== 1'b0) $display("FAIL to_early cycle=%0d got=%b exp=0", i, ack_end); else pass_cnt++;
        end
        step();
        total_cnt++; if ({ack_end, timeout_err} !== 2'b11) $display("FAIL to_fire got=%b exp=11", {ack_end, timeout_err}); else pass_cnt++;
        step();
        step();
        total_cnt++; if ({busy, timeout_err} !== 2'b01) $display("FAIL to_sticky got=%b exp=01", {busy, timeout_err}); else pass_cnt++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_clear got=%b exp=0", timeout_err); else pass_cnt++;
        // svc_done on the last allowed SERVICE cycle completes normally
        irq_req[7] = 1'b0;
        step();
        irq_req[7] = 1'b1;
        step();
        step();
        step();
        repeat (15) step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        total_cnt++; if ({ack_end, timeout_err} !== 2'b10) $display("FAIL to_done_wins got=%b exp=10", {ack_end, timeout_err}); else pass_cnt++;
        // err_clr held across a fresh timeout: the set wins
        irq_req[7] = 1'b0;
        step();
        irq_req[7] = 1'b1;
        step();
        step();
        step();
        repeat (15) step();
        err_clr = 1'b1;
        step();
        total_cnt++; if ({ack_end, timeout_err} !== 2'b11) $display("FAIL to_set_wins got=%b exp=11", {ack_end, timeout_err}); else pass_cnt++;
        step();
        err_clr = 1'b0;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_clear2 got=%b exp=0", timeout_err); else pass_cnt++;
        irq_req[7] = 1'b0;
        step();
    endtask

    task automatic test_set_wins();
        sw_flag[9] = 1'b1;
        step();
        total_cnt++; if (pending[9] !== 1'b1) $display("FAIL setw_pend got=%b exp=1", pending[9]); else pass_cnt++;
        step();
        sw_flag = '0;
        total_cnt++; if ({ack_start, int_ID, pending[9]} !== {1'b1, 5'd9, 1'b1})
            $display("FAIL setw_grant got=%b/%0d/%b exp=1/9/1", ack_start, int_ID, pending[9]); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        step();
        step();
        total_cnt++; if ({ack_start, int_ID, pending[9]} !== {1'b1, 5'd9, 1'b0})
            $display("FAIL setw_redispatch got=%b/%0d/%b exp=1/9/0", ack_start, int_ID, pending[9]); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_service();
        irq_req[12] = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        total_cnt++; if ({pending, int_ID, ack_start, ack_end, busy, timeout_err} !== '0)
            $display("FAIL rstmid_outputs got=%h/%0d/%b exp=0/0/0000", pending, int_ID, {ack_start, ack_end, busy, timeout_err}); else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++; if ({ack_end, pending[12]} !== 2'b01) $display("FAIL rstmid_repend got=%b exp=01", {ack_end, pending[12]}); else pass_cnt++;
        step();
        total_cnt++; if ({ack_start, int_ID} !== {1'b1, 5'd12}) $display("FAIL rstmid_redispatch got=%b/%0d exp=1/12", ack_start, int_ID); else pass_cnt++;
        step();
        svc_done = 1'b1;
        step();
        svc_done = 1'b0;
        irq_req = '0;
        step();
    endtask

    task automatic test_random();
        bit [3:0] exp_flags;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                irq_req = irq_req ^ ($urandom & $urandom & $urandom & $urandom & $urandom);
            sw_flag  = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            if ($urandom_range(0, 49) == 0) irq_mask = $urandom & $urandom;
            svc_done = ($urandom_range(0, 9) == 0);
            err_clr  = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            step();
            exp_flags = {m_phase == 1, m_phase == 3, m_phase != 0, m_err};
            total_cnt++; if (pending !== m_pend) $display("FAIL rand_pending cyc=%0d got=%h exp=%h", c, pending, m_pend); else pass_cnt++;
            total_cnt++; if (int_ID !== m_id) $display("FAIL rand_int_ID cyc=%0d got=%0d exp=%0d", c, int_ID, m_id); else pass_cnt++;
            total_cnt++; if ({ack_start, ack_end, busy, timeout_err} !== exp_flags)
                $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, {ack_start, ack_end, busy, timeout_err}, exp_flags); else pass_cnt++;
        end
        rst = 1'b0; sw_flag = '0; svc_done = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_req = '0; sw_flag = '0; irq_mask = '0; svc_done = 1'b0; err_clr = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_timeout();
        test_set_wins();
        test_reset_mid_service();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
